// File: rtl/ysyx_22040237_lsu_pkg.sv
// rtl/ysyx_22040237_lsu_pkg.sv - shared load/store info bit indices, size and FSM encodings
package ysyx_22040237_lsu_pkg;

  // ls_info_bus bit positions
  localparam int LS_LOAD   = 0;
  localparam int LS_STORE  = 1;
  localparam int LS_USIGN  = 2;
  localparam int LS_BYTE   = 3;
  localparam int LS_DB     = 4;
  localparam int LS_WORD   = 5;
  localparam int LS_DW     = 6;
  localparam int LS_INFO_W = 7;

  // access size encodings
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // LSU FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Size from the one-hot size bits; only meaningful once legality is checked
  function automatic size_e info_size(input logic [LS_INFO_W-1:0] info);
    if (info[LS_DW])        return SZ_D;
    else if (info[LS_WORD]) return SZ_W;
    else if (info[LS_DB])   return SZ_H;
    else                    return SZ_B;
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// rtl/ysyx_22040237_lsu_align.sv - byte-lane shift, write strobes, alignment check and load extension
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
(
  input  logic [6:0]  info,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic        legal,
  output logic        aligned,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_ext
);

  logic [5:0]  sh;
  logic [7:0]  strb_base;
  logic [63:0] raw;
  logic        usign;
  size_e       sz;

  assign sh    = {addr_lo, 3'b000};
  assign usign = info[LS_USIGN];
  assign sz    = info_size(info);

  // Decode legality/alignment and extend the lane-shifted read data
  always_comb begin
    legal     = (info[LS_LOAD] ^ info[LS_STORE]) && $onehot(info[LS_DW:LS_BYTE]);
    raw       = rdata >> sh;
    aligned   = 1'b0;
    strb_base = 8'h00;
    rdata_ext = raw;
    case (sz)
      SZ_B: begin
        aligned   = 1'b1;
        strb_base = 8'h01;
        rdata_ext = usign ? {56'd0, raw[7:0]} : {{56{raw[7]}}, raw[7:0]};
      end
      SZ_H: begin
        aligned   = (addr_lo[0] == 1'b0);
        strb_base = 8'h03;
        rdata_ext = usign ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      end
      SZ_W: begin
        aligned   = (addr_lo[1:0] == 2'b00);
        strb_base = 8'h0F;
        rdata_ext = usign ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      end
      default: begin
        aligned   = (addr_lo == 3'b000);
        strb_base = 8'hFF;
        rdata_ext = raw;
      end
    endcase
  end

  assign wstrb      = info[LS_STORE] ? (strb_base << addr_lo) : 8'h00;
  assign wdata_lane = wdata << sh;

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// rtl/ysyx_22040237_lsu.sv - load/store unit: EXU request to valid/ready data-memory bus and write-back
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid_i,
  input  logic [6:0]  ls_info_bus_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        rd_wr_en_i,
  input  logic [4:0]  rd_idx_i,
  output logic        lsu_busy_o,
  output logic        wb_valid_o,
  output logic        wb_rd_wr_en_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [63:0] wb_data_o,
  output logic        err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_req_wen_o,
  output logic [63:0] mem_req_addr_o,
  output logic [63:0] mem_req_wdata_o,
  output logic [7:0]  mem_req_wstrb_o,
  input  logic        mem_rsp_valid_i,
  input  logic [63:0] mem_rsp_rdata_i,
  output logic        mem_rsp_ready_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e        state;
  logic [6:0]    info_q;
  logic [2:0]    addr_lo_q;
  logic [4:0]    rd_idx_q;
  logic          rd_wr_en_q;
  logic [CW-1:0] cnt;

  logic [6:0]    al_info;
  logic [2:0]    al_addr_lo;
  logic          al_legal;
  logic          al_aligned;
  logic [7:0]    al_wstrb;
  logic [63:0]   al_wdata;
  logic [63:0]   al_rdata;

  // In IDLE the aligner looks at the incoming request; afterwards at the captured one
  assign al_info    = (state == ST_IDLE) ? ls_info_bus_i : info_q;
  assign al_addr_lo = (state == ST_IDLE) ? addr_i[2:0]   : addr_lo_q;

  ysyx_22040237_lsu_align u_align (
    .info       (al_info),
    .addr_lo    (al_addr_lo),
    .wdata      (wdata_i),
    .rdata      (mem_rsp_rdata_i),
    .legal      (al_legal),
    .aligned    (al_aligned),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  // Busy is combinational so the core stalls in the very cycle it issues the request
  assign lsu_busy_o = ~rst & (((state == ST_IDLE) & ls_valid_i) | (state == ST_REQ) | (state == ST_RSP));

  // LSU control FSM with registered bus and write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      info_q          <= 7'd0;
      addr_lo_q       <= 3'd0;
      rd_idx_q        <= 5'd0;
      rd_wr_en_q      <= 1'b0;
      cnt             <= '0;
      wb_valid_o      <= 1'b0;
      wb_rd_wr_en_o   <= 1'b0;
      wb_rd_idx_o     <= 5'd0;
      wb_data_o       <= 64'd0;
      err_o           <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_wen_o   <= 1'b0;
      mem_req_addr_o  <= 64'd0;
      mem_req_wdata_o <= 64'd0;
      mem_req_wstrb_o <= 8'd0;
      mem_rsp_ready_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ls_valid_i) begin
            if (al_legal && al_aligned) begin
              info_q          <= ls_info_bus_i;
              addr_lo_q       <= addr_i[2:0];
              rd_idx_q        <= rd_idx_i;
              rd_wr_en_q      <= rd_wr_en_i;
              mem_req_valid_o <= 1'b1;
              mem_req_wen_o   <= ls_info_bus_i[LS_STORE];
              mem_req_addr_o  <= {addr_i[63:3], 3'b000};
              mem_req_wdata_o <= al_wdata;
              mem_req_wstrb_o <= al_wstrb;
              state           <= ST_REQ;
            end else begin
              // rejected without touching the bus
              wb_valid_o    <= 1'b1;
              err_o         <= 1'b1;
              wb_rd_wr_en_o <= 1'b0;
              wb_rd_idx_o   <= rd_idx_i;
              wb_data_o     <= 64'd0;
              state         <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_rsp_ready_o <= 1'b1;
            cnt             <= '0;
            state           <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (mem_rsp_valid_i) begin
            mem_rsp_ready_o <= 1'b0;
            wb_valid_o      <= 1'b1;
            err_o           <= 1'b0;
            wb_rd_wr_en_o   <= info_q[LS_LOAD] & rd_wr_en_q;
            wb_rd_idx_o     <= rd_idx_q;
            wb_data_o       <= info_q[LS_LOAD] ? al_rdata : 64'd0;
            state           <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            mem_rsp_ready_o <= 1'b0;
            wb_valid_o      <= 1'b1;
            err_o           <= 1'b1;
            wb_rd_wr_en_o   <= 1'b0;
            wb_rd_idx_o     <= rd_idx_q;
            wb_data_o       <= 64'd0;
            state           <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          wb_valid_o    <= 1'b0;
          err_o         <= 1'b0;
          wb_rd_wr_en_o <= 1'b0;
          wb_rd_idx_o   <= 5'd0;
          wb_data_o     <= 64'd0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// tb/tb_ysyx_22040237_lsu.sv - self-checking bench for the load/store unit
module tb_ysyx_22040237_lsu;

  localparam int TIMEOUT_CYC = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ls_valid_i = 1'b0;
  logic [6:0]  ls_info_bus_i = 7'd0;
  logic [63:0] addr_i = 64'd0;
  logic [63:0] wdata_i = 64'd0;
  logic        rd_wr_en_i = 1'b0;
  logic [4:0]  rd_idx_i = 5'd0;
  logic        lsu_busy_o;
  logic        wb_valid_o;
  logic        wb_rd_wr_en_o;
  logic [4:0]  wb_rd_idx_o;
  logic [63:0] wb_data_o;
  logic        err_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic        mem_req_wen_o;
  logic [63:0] mem_req_addr_o;
  logic [63:0] mem_req_wdata_o;
  logic [7:0]  mem_req_wstrb_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [63:0] mem_rsp_rdata_i = 64'd0;
  logic        mem_rsp_ready_o;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_22040237_lsu #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk             (clk),
    .rst             (rst),
    .ls_valid_i      (ls_valid_i),
    .ls_info_bus_i   (ls_info_bus_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .rd_wr_en_i      (rd_wr_en_i),
    .rd_idx_i        (rd_idx_i),
    .lsu_busy_o      (lsu_busy_o),
    .wb_valid_o      (wb_valid_o),
    .wb_rd_wr_en_o   (wb_rd_wr_en_o),
    .wb_rd_idx_o     (wb_rd_idx_o),
    .wb_data_o       (wb_data_o),
    .err_o           (err_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_wen_o   (mem_req_wen_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_wstrb_o (mem_req_wstrb_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i),
    .mem_rsp_ready_o (mem_rsp_ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access rules in plain arithmetic ----
  function automatic logic [6:0] mk(input bit ld, input bit st, input bit us, input int sz_bytes);
    logic [6:0] v;
    v = {3'b000, (sz_bytes == 1), us, st, ld};
    v[4] = (sz_bytes == 2);
    v[5] = (sz_bytes == 4);
    v[6] = (sz_bytes == 8);
    return v;
  endfunction

  function automatic int nbytes(input logic [6:0] info);
    if (info[6]) return 8;
    if (info[5]) return 4;
    if (info[4]) return 2;
    return 1;
  endfunction

  function automatic bit m_ok(input logic [6:0] info, input logic [63:0] addr);
    int ops, sizes;
    ops   = int'(info[0]) + int'(info[1]);
    sizes = int'(info[3]) + int'(info[4]) + int'(info[5]) + int'(info[6]);
    if (ops != 1 || sizes != 1) return 1'b0;
    return (int'(addr[2:0]) % nbytes(info)) == 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [6:0] info, input logic [63:0] addr);
    logic [7:0] s;
    int a, n;
    s = 8'h00;
    a = int'(addr[2:0]);
    n = nbytes(info);
    if (info[1])
      for (int i = 0; i < 8; i++)
        if (i >= a && i < a + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_load(input logic [6:0] info, input logic [63:0] addr, input logic [63:0] rdata);
    logic [63:0] v, mask;
    int n;
    n = nbytes(info);
    v = rdata >> (8 * int'(addr[2:0]));
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (!info[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // One complete access with given handshake delays; checks bus and write-back
  task automatic run_access(input string tag, input logic [6:0] info, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] rdata, input logic [4:0] rd,
                            input int rdly, input int sdly, output logic [63:0] got, output logic got_err);
    bit ok;
    ok = m_ok(info, addr);
    @(negedge clk);
    ls_valid_i = 1'b1; ls_info_bus_i = info; addr_i = addr; wdata_i = wdata;
    rd_idx_i = rd; rd_wr_en_i = info[0];
    #1 chk({tag, " busy_req"}, 64'(lsu_busy_o), 64'd1);
    @(negedge clk);
    ls_valid_i = 1'b0;
    addr_i = {$urandom, $urandom}; wdata_i = {$urandom, $urandom}; rd_idx_i = 5'($urandom);
    if (!ok) begin
      chk({tag, " err_wb"}, 64'(wb_valid_o), 64'd1);
      chk({tag, " err_flag"}, 64'(err_o), 64'd1);
      chk({tag, " err_noreq"}, 64'(mem_req_valid_o), 64'd0);
      chk({tag, " err_wen"}, 64'(wb_rd_wr_en_o), 64'd0);
      chk({tag, " err_data"}, wb_data_o, 64'd0);
      got = wb_data_o; got_err = err_o;
    end else begin
      for (int k = 0; k <= rdly; k++) begin
        mem_req_ready_i = (k == rdly);
        chk({tag, " req_valid"}, 64'(mem_req_valid_o), 64'd1);
        chk({tag, " req_addr"}, mem_req_addr_o, {addr[63:3], 3'b000});
        chk({tag, " req_wen"}, 64'(mem_req_wen_o), 64'(info[1]));
        chk({tag, " req_strb"}, 64'(mem_req_wstrb_o), 64'(m_strb(info, addr)));
        if (info[1]) chk({tag, " req_wdata"}, mem_req_wdata_o, wdata << (8 * int'(addr[2:0])));
        chk({tag, " busy_req"}, 64'(lsu_busy_o), 64'd1);
        @(negedge clk);
      end
      mem_req_ready_i = 1'b0;
      for (int k = 0; k <= sdly; k++) begin
        mem_rsp_valid_i = (k == sdly);
        mem_rsp_rdata_i = (k == sdly) ? rdata : {$urandom, $urandom};
        chk({tag, " rsp_ready"}, 64'(mem_rsp_ready_o), 64'd1);
        chk({tag, " busy_rsp"}, 64'(lsu_busy_o), 64'd1);
        @(negedge clk);
      end
      mem_rsp_valid_i = 1'b0;
      chk({tag, " wb_valid"}, 64'(wb_valid_o), 64'd1);
      chk({tag, " wb_err"}, 64'(err_o), 64'd0);
      chk({tag, " wb_data"}, wb_data_o, info[0] ? m_load(info, addr, rdata) : 64'd0);
      chk({tag, " wb_wen"}, 64'(wb_rd_wr_en_o), 64'(info[0]));
      chk({tag, " wb_rd"}, 64'(wb_rd_idx_o), 64'(rd));
      chk({tag, " busy_done"}, 64'(lsu_busy_o), 64'd0);
      got = wb_data_o; got_err = err_o;
    end
    @(negedge clk);
    chk({tag, " wb_pulse"}, 64'(wb_valid_o), 64'd0);
  endtask

  logic [63:0] got;
  logic        gerr;
  int          cyc;
  int          rspc;

  initial begin
    // reset state
    #3;
    chk("rst_busy", 64'(lsu_busy_o), 64'd0);
    chk("rst_wb", 64'(wb_valid_o), 64'd0);
    chk("rst_req", 64'(mem_req_valid_o), 64'd0);
    chk("rst_rsp", 64'(mem_rsp_ready_o), 64'd0);
    chk("rst_addr", mem_req_addr_o, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // directed vectors
    run_access("lb", mk(1,0,0,1), 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_7F00, 5'd3, 0, 0, got, gerr);
    chk("lb_const", got, 64'hFFFF_FFFF_FFFF_FF80);
    run_access("lhu", mk(1,0,1,2), 64'h8000_0006, 64'd0, 64'hBEEF_0000_0000_0000, 5'd4, 0, 0, got, gerr);
    chk("lhu_const", got, 64'h0000_0000_0000_BEEF);
    run_access("lw", mk(1,0,0,4), 64'h8000_0004, 64'd0, 64'hBEEF_0000_0000_0000, 5'd5, 0, 0, got, gerr);
    chk("lw_const", got, 64'hFFFF_FFFF_BEEF_0000);
    run_access("sw", mk(0,1,0,4), 64'h8000_0004, 64'h1122_3344, 64'd0, 5'd6, 0, 0, got, gerr);
    chk("sw_const", got, 64'd0);
    run_access("ld_mis", mk(1,0,0,8), 64'h8000_0004, 64'd0, 64'd0, 5'd7, 0, 0, got, gerr);
    chk("ld_mis_err", 64'(gerr), 64'd1);
    run_access("illegal", 7'b0000011, 64'h8000_0000, 64'd0, 64'd0, 5'd8, 0, 0, got, gerr);
    chk("illegal_err", 64'(gerr), 64'd1);
    run_access("ready_stall", mk(1,0,0,8), 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd9, 5, 2, got, gerr);
    run_access("ld_x0", mk(1,0,0,8), 64'h8000_0018, 64'd0, 64'hCAFE_F00D_DEAD_BEEF, 5'd0, 0, 1, got, gerr);
    run_access("sd", mk(0,1,0,8), 64'h8000_0020, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 5'd1, 1, 0, got, gerr);

    // randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      logic [6:0]  info;
      logic [63:0] a;
      int          szs [4] = '{1, 2, 4, 8};
      if ($urandom_range(0, 7) == 0) info = 7'($urandom);
      else begin
        bit ld;
        ld = bit'($urandom_range(0, 1));
        info = mk(ld, !ld, bit'($urandom_range(0, 1)), szs[$urandom_range(0, 3)]);
      end
      a = {32'h0, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(info) - 1);
      run_access("rand", info, a, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got, gerr);
    end

    // response timeout
    @(negedge clk);
    ls_valid_i = 1'b1; ls_info_bus_i = mk(1,0,0,4); addr_i = 64'h8000_0040; rd_idx_i = 5'd2; rd_wr_en_i = 1'b1;
    @(negedge clk);
    ls_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    rspc = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (wb_valid_o) break;
      if (mem_rsp_ready_o) rspc++;
      @(negedge clk);
    end
    chk("to_bound", 64'(cyc < 400), 64'd1);
    chk("to_cycles", 64'(rspc), 64'(TIMEOUT_CYC));
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_wen", 64'(wb_rd_wr_en_o), 64'd0);
    chk("to_data", wb_data_o, 64'd0);
    @(negedge clk);

    // reset asserted while waiting for a response
    ls_valid_i = 1'b1; ls_info_bus_i = mk(1,0,0,8); addr_i = 64'h8000_0080; rd_idx_i = 5'd10;
    @(negedge clk);
    ls_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    chk("mr_in_rsp", 64'(mem_rsp_ready_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", 64'(lsu_busy_o), 64'd0);
    chk("mr_rsp", 64'(mem_rsp_ready_o), 64'd0);
    chk("mr_req", 64'(mem_req_valid_o), 64'd0);
    chk("mr_addr", mem_req_addr_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 64'h1111_2222_3333_4444;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_late_wb", 64'(wb_valid_o), 64'd0);
      chk("mr_late_rdy", 64'(mem_rsp_ready_o), 64'd0);
    end
    mem_rsp_valid_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
